// File: rtl/melody_pkg.sv
// ============================================================================
// Module   : melody_pkg
// Purpose  : Shared types and constants for the alarm melody sequencer.
//            Holds the sequencer state encoding, the rest-note code,
//            default bus widths and the duration counter width helper.
// Ports    : none (package)
// Config   : MELODY_LOOP_EN (used by melody_sequencer, not here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package melody_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NOTE_W = 8;

  // Note code 0 is silence.
  localparam int REST_NOTE = 0;

  // Counter wide enough to hold NOTE_TICKS-1 with one spare bit.
  function automatic int dur_cnt_width(input int ticks);
    return $clog2(ticks) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_duration_counter.sv
// ============================================================================
// Module   : note_duration_counter
// Purpose  : Beat-tick down-counter that times how long one ROM slot is
//            held. Synchronous clear, load of a fixed value, decrement that
//            saturates at zero, and a zero flag.
// Ports    : clk     - system clock
//            rst_n   - synchronous active-low reset
//            clr_i   - force count to zero (highest priority after reset)
//            load_i  - load LOAD_VAL
//            dec_i   - decrement when non-zero
//            zero_o  - count equals zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_duration_counter #(
  parameter int CNT_W    = 3,
  parameter int LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/melody_sequencer.sv
// ============================================================================
// Module   : melody_sequencer
// Purpose  : Steps the alarm melody ROM (registered read, one-cycle latency)
//            and presents the current note to the tone generator. Each ROM
//            slot is held for NOTE_TICKS beat ticks.
// Ports    : clk        - system clock
//            rst_n      - synchronous active-low reset
//            start      - begin playback (honoured only in IDLE)
//            stop       - abort playback, highest priority
//            tick       - one-cycle beat enable
//            rom_note   - registered ROM data for rom_addr
//            rom_addr   - ROM address
//            note_out   - current note code
//            note_valid - tone enable (PLAY and note_out non-rest)
//            busy       - not IDLE
//            done       - one-cycle pulse on natural melody completion
// Config   : MELODY_LOOP_EN - when defined, the melody repeats from slot 0
//            until stopped and done never pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_sequencer
  import melody_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int LAST_ADDR  = 31,
  parameter int NOTE_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = dur_cnt_width(NOTE_TICKS);
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(REST_NOTE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [NOTE_W-1:0] note_q,  note_d;
  logic              done_q,  done_d;

  logic cnt_clr;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  note_duration_counter #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (NOTE_TICKS - 1)
  ) u_dur_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if ((state_q != ST_IDLE) && stop) begin
      // Abort: silence immediately, rewind, and never flag completion.
      state_d = ST_IDLE;
      addr_d  = '0;
      note_d  = REST;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            addr_d  = '0;
            state_d = ST_FETCH;
          end
        end
        // ROM registers rom_addr on this edge; its data is valid in LOAD.
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          note_d   = rom_note;
          cnt_load = 1'b1;
          state_d  = ST_PLAY;
        end
        ST_PLAY: begin
          if (tick) begin
            if (!cnt_zero) begin
              cnt_dec = 1'b1;
            end else if (addr_q != LAST) begin
              addr_d  = addr_q + 1'b1;
              state_d = ST_FETCH;
            end else begin
`ifdef MELODY_LOOP_EN
              addr_d  = '0;
              state_d = ST_FETCH;
`else
              note_d  = REST;
              done_d  = 1'b1;
              state_d = ST_IDLE;
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      note_q  <= REST;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note_out   = note_q;
  assign note_valid = (state_q == ST_PLAY) && (note_q != REST);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_melody_sequencer.sv
// ============================================================================
// Module   : tb_melody_sequencer
// Purpose  : Self-checking directed bench for melody_sequencer with a
//            registered-read melody ROM model and a 1-in-10 beat tick.
// Config   : MELODY_LOOP_EN selects the looping scenario instead of the
//            single-pass completion scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       tick_auto;
  logic       tick_force;
  logic       tick_en;
  logic       tick;
  logic [7:0] rom_note;
  logic [4:0] rom_addr;
  logic [7:0] note_out;
  logic       note_valid;
  logic       busy;
  logic       done;

  logic [7:0] rom_mem [32];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int tcnt      = 0;

  assign tick = tick_auto | tick_force;

  always #5 clk = ~clk;

  melody_sequencer #(
    .ADDR_W     (5),
    .NOTE_W     (8),
    .LAST_ADDR  (31),
    .NOTE_TICKS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .rom_note   (rom_note),
    .rom_addr   (rom_addr),
    .note_out   (note_out),
    .note_valid (note_valid),
    .busy       (busy),
    .done       (done)
  );

  // Melody ROM: registered read, one cycle of latency.
  always @(posedge clk) rom_note <= rom_mem[rom_addr];

  // Beat prescaler: one tick every 10 cycles while enabled.
  initial begin
    tick_auto = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      tick_auto = tick_en && (tcnt % 10 == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk); stop = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); stop = 1'b0;
  endtask

  // Returns once the sequencer is in PLAY for the requested slot.
  task automatic wait_play_slot(input logic [4:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rom_addr == target && busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({rom_addr, note_out, note_valid, busy, done} !== 16'd0)
      $display("FAIL reset_outputs: got addr=%0d note=%0d nv=%b busy=%b done=%b, want all 0",
               rom_addr, note_out, note_valid, busy, done);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_first_note();
    int  n;
    bit  held;
    tick_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b1 || rom_addr !== 5'd0)
      $display("FAIL start_edge0: busy=%b addr=%0d want 1/0", busy, rom_addr);
    else pass_cnt++;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (note_out !== 8'd0) $display("FAIL edge1_note: got %0d want 0", note_out);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (note_out !== 8'd22 || note_valid !== 1'b1)
      $display("FAIL edge2_note: got %0d nv=%b want 22/1", note_out, note_valid);
    else pass_cnt++;
    tcnt = 0; tick_en = 1'b1;
    n = 0; held = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (tick) n++;
      #1;
      if (rom_addr == 5'd1) break;
      if (note_out !== 8'd22 || note_valid !== 1'b1) held = 1'b0;
    end
    total_cnt++;
    if (n != 4) $display("FAIL slot0_ticks: got %0d want 4", n);
    else pass_cnt++;
    total_cnt++;
    if (!held) $display("FAIL slot0_held: note not held at 22 through slot");
    else pass_cnt++;
    total_cnt++;
    if (note_valid !== 1'b0 || busy !== 1'b1 || note_out !== 8'd22)
      $display("FAIL fetch_gap: nv=%b busy=%b note=%0d want 0/1/22", note_valid, busy, note_out);
    else pass_cnt++;
    repeat (2) begin @(posedge clk); #1; end
    total_cnt++;
    if (note_out !== 8'd0 || note_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL slot1_rest: note=%0d nv=%b busy=%b want 0/0/1", note_out, note_valid, busy);
    else pass_cnt++;
    do_stop();
  endtask

  task automatic test_tick_fetch_load();
    tick_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; tick_force = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    total_cnt++;
    if (note_out !== 8'd22 || note_valid !== 1'b1)
      $display("FAIL tfl_play: note=%0d nv=%b want 22/1", note_out, note_valid);
    else pass_cnt++;
    @(negedge clk); tick_force = 1'b0;
    repeat (3) begin
      @(negedge clk); tick_force = 1'b1;
      @(negedge clk); tick_force = 1'b0;
    end
    repeat (3) @(negedge clk);
    total_cnt++;
    if (rom_addr !== 5'd0) $display("FAIL tfl_three_ticks: addr=%0d want 0", rom_addr);
    else pass_cnt++;
    @(negedge clk); tick_force = 1'b1;
    @(negedge clk); tick_force = 1'b0;
    total_cnt++;
    if (rom_addr !== 5'd1) $display("FAIL tfl_fourth_tick: addr=%0d want 1", rom_addr);
    else pass_cnt++;
    do_stop();
  endtask

`ifndef MELODY_LOOP_EN
  task automatic test_full_run();
    logic [4:0] prev, addr_last;
    bit   walk_ok, note_ok, nv_last, got_done, idle_ok;
    int   ticks31, done_cnt;
    tick_en = 1'b1;
    do_start();
    prev = 5'd0; walk_ok = 1'b1; note_ok = 1'b1; nv_last = 1'b0; addr_last = 5'd0;
    ticks31 = 0; done_cnt = 0; got_done = 1'b0; idle_ok = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit t;
      @(posedge clk);
      t = tick;
      #1;
      if (t && nv_last && addr_last == 5'd31) ticks31++;
      if (rom_addr != prev) begin
        if (rom_addr != prev + 5'd1) walk_ok = 1'b0;
        prev = rom_addr;
      end
      if (note_valid && note_out !== rom_mem[rom_addr]) note_ok = 1'b0;
      nv_last = note_valid; addr_last = rom_addr;
      if (done) begin
        got_done = 1'b1;
        if (busy !== 1'b0 || note_out !== 8'd0) idle_ok = 1'b0;
        break;
      end
    end
    total_cnt++;
    if (!got_done) $display("FAIL full_done_timeout: done=0 want pulse");
    else pass_cnt++;
    total_cnt++;
    if (!walk_ok || prev !== 5'd31) $display("FAIL full_walk: last=%0d ok=%b want 31/1", prev, walk_ok);
    else pass_cnt++;
    total_cnt++;
    if (!note_ok) $display("FAIL full_notes: note_out differed from ROM during PLAY");
    else pass_cnt++;
    total_cnt++;
    if (ticks31 != 4) $display("FAIL slot31_ticks: got %0d want 4", ticks31);
    else pass_cnt++;
    total_cnt++;
    if (!idle_ok) $display("FAIL done_idle: busy=%b note=%0d want 0/0", busy, note_out);
    else pass_cnt++;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    total_cnt++;
    if (done_cnt != 0 || busy !== 1'b0)
      $display("FAIL done_single: extra pulses=%0d busy=%b want 0/0", done_cnt, busy);
    else pass_cnt++;
  endtask
`else
  task automatic test_loop();
    logic [4:0] prev;
    int  wraps, pending;
    bit  note_ok, done_seen;
    tick_en = 1'b1;
    do_start();
    prev = 5'd0; wraps = 0; pending = 0; note_ok = 1'b1; done_seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
      if (pending != 0) begin
        pending--;
        if (pending == 0) begin
          if (note_out !== 8'd22) note_ok = 1'b0;
          if (wraps == 3) break;
        end
      end
      if (prev == 5'd31 && rom_addr == 5'd0) begin
        wraps++;
        pending = 2;
      end
      prev = rom_addr;
    end
    total_cnt++;
    if (wraps != 3) $display("FAIL loop_wraps: got %0d want 3", wraps);
    else pass_cnt++;
    total_cnt++;
    if (!note_ok) $display("FAIL loop_note: note after wrap not 22");
    else pass_cnt++;
    total_cnt++;
    if (done_seen) $display("FAIL loop_done: done pulsed, want 0");
    else pass_cnt++;
    do_stop();
  endtask
`endif

  task automatic test_stop_slot4();
    bit ok;
    tick_en = 1'b1;
    do_start();
    wait_play_slot(5'd4, ok);
    total_cnt++;
    if (!ok || note_out !== 8'd29 || note_valid !== 1'b1)
      $display("FAIL stop_slot4_note: ok=%b note=%0d nv=%b want 1/29/1", ok, note_out, note_valid);
    else pass_cnt++;
    @(negedge clk); stop = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || note_out !== 8'd0 || rom_addr !== 5'd0 || done !== 1'b0 || note_valid !== 1'b0)
      $display("FAIL stop_outputs: busy=%b note=%0d addr=%0d done=%b nv=%b want all 0",
               busy, note_out, rom_addr, done, note_valid);
    else pass_cnt++;
    @(negedge clk); stop = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL stop_stays_idle: busy=%b done=%b want 0/0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_start_stop_same();
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL start_stop_same: busy=%b want 0", busy);
    else pass_cnt++;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || rom_addr !== 5'd0) $display("FAIL start_stop_after: busy=%b addr=%0d want 0/0", busy, rom_addr);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    bit ok, changed;
    tick_en = 1'b1;
    do_start();
    wait_play_slot(5'd2, ok);
    @(negedge clk); start = 1'b1;
    changed = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rom_addr != 5'd2) begin changed = 1'b1; break; end
    end
    total_cnt++;
    if (!ok || !changed || rom_addr !== 5'd3)
      $display("FAIL busy_start_next: ok=%b changed=%b addr=%0d want 1/1/3", ok, changed, rom_addr);
    else pass_cnt++;
    repeat (3) begin @(posedge clk); #1; end
    total_cnt++;
    if (rom_addr !== 5'd3 || busy !== 1'b1 || note_out !== rom_mem[3])
      $display("FAIL busy_start_hold: addr=%0d busy=%b note=%0d want 3/1/%0d", rom_addr, busy, note_out, rom_mem[3]);
    else pass_cnt++;
    @(negedge clk); start = 1'b0;
    do_stop();
  endtask

  task automatic test_reset_mid();
    bit ok;
    tick_en = 1'b1;
    do_start();
    wait_play_slot(5'd10, ok);
    repeat (12) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (!ok || {rom_addr, note_out, note_valid, busy, done} !== 16'd0)
      $display("FAIL reset_mid: ok=%b addr=%0d note=%0d nv=%b busy=%b done=%b want 1 then all 0",
               ok, rom_addr, note_out, note_valid, busy, done);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || rom_addr !== 5'd0 || note_out !== 8'd0)
      $display("FAIL reset_no_resume: busy=%b addr=%0d note=%0d want 0/0/0", busy, rom_addr, note_out);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = 8'(i + 40);
    rom_mem[0] = 8'd22;
    rom_mem[1] = 8'd0;
    rom_mem[4] = 8'd29;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    tick_force = 1'b0; tick_en = 1'b0;

    test_reset();
    test_first_note();
    test_tick_fetch_load();
`ifndef MELODY_LOOP_EN
    test_full_run();
`else
    test_loop();
`endif
    test_stop_slot4();
    test_start_stop_same();
    test_start_while_busy();
    test_reset_mid();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
